cpu_flags_mt: RTL

Per-thread CPU flag store and condition evaluator for the multi-threaded sha256crypt CPU. It is the parametrised successor to the single-port flag store. Flag width, thread count and condition encoding are parameters. Flag memory is cleared after reset by an init sweep. A second, handshaked port lets external units (e.g. a unit-done event) OR flags into any thread's saved context while the CPU keeps running. It sits between the thread scheduler (load/save), the instruction decoder (condition, set_flags) and external event sources.

---
 rtl/cpu_flags_mt_pkg.sv | 59 +++++
 rtl/cpu_flags_mt_cond.sv | 35 +++
 rtl/cpu_flags_mt.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_flags_mt_pkg.sv
// Shared definitions for the multi-threaded CPU flag store.
// Contents: index helper function, default flag/condition geometry, condition field positions,
// flag index constants, named condition codes and the flag-store state type.
package cpu_flags_mt_pkg;

  // Position of the highest set bit (0 for inputs 0 and 1).
  function automatic int msb(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  localparam int CPU_N_FLAGS    = 4;
  localparam int CPU_FLAG_IDX_W = msb(CPU_N_FLAGS - 1) + 1;
  localparam int CPU_COND_LEN   = CPU_FLAG_IDX_W + 2;

  // Condition field layout: {always, invert, flag index}.
  localparam int COND_ALWAYS_BIT = CPU_COND_LEN - 1;
  localparam int COND_INVERT_BIT = CPU_COND_LEN - 2;
  localparam int COND_IDX_LSB    = 0;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ONE   = 2;
  localparam int FLAG_UF    = 3;

  typedef logic [CPU_COND_LEN-1:0] cond_t;

  function automatic cond_t mk_cond(input int idx, input bit inv);
    cond_t c;
    c = '0;
    c[CPU_FLAG_IDX_W-1:0] = idx[CPU_FLAG_IDX_W-1:0];
    c[COND_INVERT_BIT]    = inv;
    return c;
  endfunction

  function automatic cond_t mk_always();
    cond_t c;
    c = '0;
    c[COND_ALWAYS_BIT] = 1'b1;
    return c;
  endfunction

  localparam cond_t IF_NONE      = mk_always();
  localparam cond_t IF_ZERO      = mk_cond(FLAG_ZERO, 1'b0);
  localparam cond_t IF_NOT_ZERO  = mk_cond(FLAG_ZERO, 1'b1);
  localparam cond_t IF_ONE       = mk_cond(FLAG_ONE, 1'b0);
  localparam cond_t IF_NOT_ONE   = mk_cond(FLAG_ONE, 1'b1);
  localparam cond_t IF_CARRY     = mk_cond(FLAG_CARRY, 1'b0);
  localparam cond_t IF_NOT_CARRY = mk_cond(FLAG_CARRY, 1'b1);
  localparam cond_t IF_UF        = mk_cond(FLAG_UF, 1'b0);
  localparam cond_t IF_NOT_UF    = mk_cond(FLAG_UF, 1'b1);

  typedef enum logic {StInit, StRun} state_t;

endpackage

// File: rtl/cpu_flags_mt_cond.sv
// Combinational condition decoder.
// Ports:
//   i_flags             live flags of the current thread
//   i_op_condition      {always, invert, flag index}
//   o_condition_is_true always bit, else selected flag xor invert; out-of-range index is false
module cpu_flags_cond
  import cpu_flags_mt_pkg::*;
#(
  parameter int N_FLAGS  = 4,
  parameter int COND_LEN = 4
) (
  input  logic [N_FLAGS-1:0]  i_flags,
  input  logic [COND_LEN-1:0] i_op_condition,
  output logic                o_condition_is_true
);

  localparam int IdxW = COND_LEN - 2;

  logic w_hit;
  logic w_bit;

  always_comb begin
    w_hit = 1'b0;
    w_bit = 1'b0;
    for (int k = 0; k < N_FLAGS; k++) begin
      if (i_op_condition[IdxW-1:0] == IdxW'(k)) begin
        w_hit = 1'b1;
        w_bit = i_flags[k];
      end
    end
    o_condition_is_true = i_op_condition[COND_LEN-1] |
                          (w_hit & (w_bit ^ i_op_condition[COND_LEN-2]));
  end

endmodule

// File: rtl/cpu_flags_mt.sv
// Per-thread flag store with condition evaluation and an external OR-set port.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset (restarts the clearing sweep)
//   ready                 high once every thread context has been cleared
//   thread_num            thread for load / save
//   load_en, save_en      context load into live flags / save of live flags
//   flags                 live flags of the current thread
//   op_condition          condition to evaluate, condition_is_true its combinational result
//   set_flags             masked update of live flags (iop_flag_mask, flags_in)
//   ext_set_en/ext_ready  handshake of the external OR-set request
//   ext_thread, ext_mask  target thread and bits to OR in
module cpu_flags_mt
  import cpu_flags_mt_pkg::*;
#(
  parameter int N_FLAGS       = 4,
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = msb(N_THREADS - 1),
  parameter int FLAG_IDX_W    = msb(N_FLAGS - 1) + 1,
  parameter int COND_LEN      = FLAG_IDX_W + 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  output logic                   ready,
  input  logic [N_THREADS_MSB:0] thread_num,
  input  logic                   load_en,
  input  logic                   save_en,
  output logic [N_FLAGS-1:0]     flags,
  input  logic [COND_LEN-1:0]    op_condition,
  output logic                   condition_is_true,
  input  logic                   set_flags,
  input  logic [N_FLAGS-1:0]     iop_flag_mask,
  input  logic [N_FLAGS-1:0]     flags_in,
  input  logic                   ext_set_en,
  output logic                   ext_ready,
  input  logic [N_THREADS_MSB:0] ext_thread,
  input  logic [N_FLAGS-1:0]     ext_mask
);

  localparam int TW = N_THREADS_MSB + 1;
  localparam logic [TW-1:0] LastEntry = TW'(N_THREADS - 1);

  state_t              r_state;
  logic [TW-1:0]       r_init_cnt;
  logic [TW-1:0]       r_cur_thread;
  logic [N_FLAGS-1:0]  r_flags;
  logic                r_pend_vld;
  logic [TW-1:0]       r_pend_thread;
  logic [N_FLAGS-1:0]  r_pend_mask;
  logic [N_FLAGS-1:0]  r_mem [N_THREADS];

  logic                w_run;
  logic                w_load;
  logic                w_save;
  logic [TW-1:0]       w_save_thread;
  logic                w_bypass;
  logic                w_ext_vld;
  logic [TW-1:0]       w_ext_thread;
  logic [N_FLAGS-1:0]  w_ext_mask;
  logic                w_ext_live;
  logic                w_ext_mem;
  logic                w_ext_hits_save;
  logic                w_ext_hits_load;
  logic                w_ext_defer;
  logic                w_ext_rmw;
  logic [N_FLAGS-1:0]  w_flags_d;
  logic                w_we;
  logic [TW-1:0]       w_waddr;
  logic [N_FLAGS-1:0]  w_wdata;

  assign w_run     = (r_state == StRun);
  assign ready     = w_run;
  assign ext_ready = w_run & ~r_pend_vld;
  assign flags     = r_flags;

  assign w_load = w_run & load_en;
  assign w_save = w_run & save_en;

  // A save issued together with a load retires the outgoing (current) thread; a save on its own
  // targets thread_num. Equal threads in that case mean the live flags simply stay.
  assign w_save_thread = load_en ? r_cur_thread : thread_num;
  assign w_bypass      = w_load & w_save & (w_save_thread == thread_num);

  // A pending request blocks new ones, so it is the only source while it is held.
  assign w_ext_vld    = w_run & (r_pend_vld | (ext_set_en & ext_ready));
  assign w_ext_thread = r_pend_vld ? r_pend_thread : ext_thread;
  assign w_ext_mask   = r_pend_vld ? r_pend_mask : ext_mask;

  assign w_ext_live      = w_ext_vld & ~w_load & (w_ext_thread == r_cur_thread);
  assign w_ext_mem       = w_ext_vld & ~w_ext_live;
  assign w_ext_hits_save = w_ext_mem & w_save & (w_ext_thread == w_save_thread);
  assign w_ext_hits_load = w_ext_mem & w_load & (w_ext_thread == thread_num);
  // The save owns the single write port, so a request to another thread waits one cycle.
  assign w_ext_defer     = w_ext_mem & w_save & ~w_ext_hits_save;
  assign w_ext_rmw       = w_ext_mem & ~w_save;

  always_comb begin
    w_flags_d = r_flags;
    if (w_load) begin
      w_flags_d = (w_bypass ? r_flags : r_mem[thread_num]) |
                  (w_ext_hits_load ? w_ext_mask : '0);
    end else if (w_run) begin
      if (set_flags) begin
        w_flags_d = (r_flags & ~iop_flag_mask) | (flags_in & iop_flag_mask);
      end
      if (w_ext_live) begin
        w_flags_d = w_flags_d | w_ext_mask;
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_cnt;
    w_wdata = '0;
    if (!RESET) begin
      if (!w_run) begin
        w_we = 1'b1;
      end else if (w_save) begin
        w_we    = 1'b1;
        w_waddr = w_save_thread;
        w_wdata = r_flags | (w_ext_hits_save ? w_ext_mask : '0);
      end else if (w_ext_rmw) begin
        w_we    = 1'b1;
        w_waddr = w_ext_thread;
        w_wdata = r_mem[w_ext_thread] | w_ext_mask;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= StInit;
      r_init_cnt    <= '0;
      r_cur_thread  <= '0;
      r_flags       <= '0;
      r_pend_vld    <= 1'b0;
      r_pend_thread <= '0;
      r_pend_mask   <= '0;
    end else begin
      r_flags <= w_flags_d;
      unique case (r_state)
        StInit: begin
          if (r_init_cnt == LastEntry) begin
            r_state <= StRun;
          end else begin
            r_init_cnt <= r_init_cnt + TW'(1);
          end
        end
        StRun: begin
          if (w_load) begin
            r_cur_thread <= thread_num;
          end
          if (w_ext_defer) begin
            r_pend_vld    <= 1'b1;
            r_pend_thread <= w_ext_thread;
            r_pend_mask   <= w_ext_mask;
          end else if (w_ext_vld) begin
            r_pend_vld <= 1'b0;
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  cpu_flags_cond #(
    .N_FLAGS  (N_FLAGS),
    .COND_LEN (COND_LEN)
  ) u_cond (
    .i_flags             (r_flags),
    .i_op_condition      (op_condition),
    .o_condition_is_true (condition_is_true)
  );

endmodule
